// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the pipeline WB request, mul/div result channel,
//               decode hazard inputs and the shared regfile write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
  // Pipeline WB stage request
  logic        pipe_wr_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  // Mul/div result channel
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  // Decode side: issue notification and source operands
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic        stall;
  // Register file write port
  logic        RegWr;
  logic [4:0]  rd;
  logic [31:0] busW;

  // Requester / environment side
  modport master (
    output pipe_wr_en, pipe_rd, pipe_data,
    output md_valid, md_rd, md_data,
    output iss_valid, iss_rd, dec_rs, dec_rt,
    input  md_ready, stall, RegWr, rd, busW
  );

  // Arbiter side
  modport slave (
    input  pipe_wr_en, pipe_rd, pipe_data,
    input  md_valid, md_rd, md_data,
    input  iss_valid, iss_rd, dec_rs, dec_rt,
    output md_ready, stall, RegWr, rd, busW
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the regfile write port between the in-order WB stage
//               and a buffered mul/div result stream, with a RAW/WAW
//               scoreboard and an anti-starvation forced drain.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  wb_port_arbiter_if.slave  io_bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [c_PTR_W:0]   c_FULL_COUNT = FIFO_DEPTH[c_PTR_W:0];
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = STARVE_MAX[c_CNT_W-1:0];

  // Result buffer storage (contents need no reset; pointers/count gate use)
  logic [4:0]         r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]        r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;

  logic [c_CNT_W-1:0] r_starve;
  logic [31:0]        r_pending;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_force;
  logic               w_pipe_req;
  logic               w_grant_fifo;
  logic [4:0]         w_head_rd;
  logic [31:0]        w_head_data;
  logic [31:0]        w_pending_nxt;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_FULL_COUNT);
  assign w_push      = io_bus.md_valid & ~w_full;
  assign w_force     = (r_starve == c_STARVE_MAX);
  assign w_pipe_req  = io_bus.pipe_wr_en & (io_bus.pipe_rd != 5'd0);
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];
  // A forced drain only occurs with a non-empty buffer, since the counter
  // clears whenever the head is granted.
  assign w_grant_fifo = ~w_empty & (w_force | ~w_pipe_req);

  // Store an accepted mul/div result at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= io_bus.md_rd;
      r_fifo_data[r_wptr] <= io_bus.md_data;
    end
  end

  // Buffer pointers and occupancy; a full buffer never enqueues, even on a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_grant_fifo) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_grant_fifo})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Count consecutive cycles a waiting head loses the port, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!w_empty && !w_grant_fifo) begin
      r_starve <= w_force ? r_starve : r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end

  // Scoreboard update: retire the granted head, then mark a new issue
  // (so a same-register set overrides the clear); $0 is never pending
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_grant_fifo) begin
      w_pending_nxt[w_head_rd] = 1'b0;
    end
    if (io_bus.iss_valid && (io_bus.iss_rd != 5'd0)) begin
      w_pending_nxt[io_bus.iss_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Write-port mux and handshake outputs, all held quiet while in reset
  always_comb begin
    io_bus.RegWr    = 1'b0;
    io_bus.rd       = 5'd0;
    io_bus.busW     = 32'd0;
    io_bus.md_ready = 1'b0;
    io_bus.stall    = 1'b0;
    if (rst_n) begin
      io_bus.md_ready = ~w_full;
      io_bus.stall    = w_force
                      | r_pending[io_bus.dec_rs]
                      | r_pending[io_bus.dec_rt]
                      | (io_bus.iss_valid & r_pending[io_bus.iss_rd]);
      if (w_grant_fifo) begin
        // A buffered result targeting $0 still pops but does not write
        io_bus.RegWr = (w_head_rd != 5'd0);
        io_bus.rd    = w_head_rd;
        io_bus.busW  = w_head_data;
      end else if (w_pipe_req) begin
        io_bus.RegWr = 1'b1;
        io_bus.rd    = io_bus.pipe_rd;
        io_bus.busW  = io_bus.pipe_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port (RegWr, rd, busW) between two requesters.
- Requester 1 is the in-order pipeline WB stage. Requester 2 is a multi-cycle mul/div unit whose results arrive out of band.
- Mul/div results are buffered in a small FIFO.
- A per-register scoreboard marks destinations with an outstanding mul/div result and raises a decode stall on RAW hazards.
- An anti-starvation counter forces the buffered results through.

Parameters:
- FIFO_DEPTH, 2, number of buffered mul/div results (power of two, ≥2).
- STARVE_MAX, 4, consecutive ungranted cycles of a non-empty FIFO before a forced drain.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pipe_wr_en  in  1  WB stage wants to write.
- pipe_rd  in  5  WB destination.
- pipe_data  in  32  WB data.
- md_valid  in  1  mul/div result valid.
- md_rd  in  5  mul/div destination.
- md_data  in  32  mul/div result.
- md_ready  out  1  FIFO can accept.
- iss_valid  in  1  decode issues a mul/div op this cycle.
- iss_rd  in  5  destination of the issued op.
- dec_rs  in  5  decode source register A.
- dec_rt  in  5  decode source register B.
- stall  out  1  freeze decode/upstream.
- RegWr  out  1  regfile write enable.
- rd  out  5  regfile write address.
- busW  out  32  regfile write data.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, scoreboard pending[31:0]=0, starvation count cnt=0, force=0.
  - While rst_n=0: RegWr=0, md_ready=0, stall=0, rd=0, busW=0.
- Outputs after reset:
  - rd, busW and RegWr are combinational from current inputs and the FIFO head.
  - The regfile captures them at the next rising edge.
- Enqueue: md_valid & md_ready at edge N pushes {md_rd, md_data}.
  - There is no bypass. The earliest write of that entry is at edge N+1.
- md_ready = !full. When full, no enqueue occurs even if a dequeue happens in the same cycle.
- Pipe request: pipe_req = pipe_wr_en & (pipe_rd≠0). A pipe write to $0 is dropped and leaves the port free.
- Grant priority per cycle:
  1. force=1 and FIFO non-empty: grant FIFO head.
  2. pipe_req: grant pipe.
  3. FIFO non-empty: grant FIFO head.
  4. Otherwise: RegWr=0.
- FIFO grant:
  - rd=head.rd, busW=head.data, RegWr=(head.rd≠0).
  - The head pops at the edge even when head.rd=0.
- Pipe grant: rd=pipe_rd, busW=pipe_data, RegWr=1.
- Pipeline contract: pipe_wr_en must be 0 in any cycle where force=1. The bench checks this.
- Starvation counter:
  - At each edge, if FIFO non-empty and head not granted: cnt<=min(cnt+1, STARVE_MAX).
  - Otherwise: cnt<=0.
  - force = (cnt==STARVE_MAX).
- Scoreboard:
  - At each edge, pending[iss_rd]<=1 if iss_valid & iss_rd≠0.
  - pending[head.rd]<=0 when the FIFO head is granted.
  - Same register set and cleared in one edge: set wins.
  - pending[0] is always 0.
- Stall: stall = force | pending[dec_rs] | pending[dec_rt] | (iss_valid & pending[iss_rd]).
  - The last term is the WAW guard: decode must not assert iss_valid to a pending rd.
- Each FIFO pointer wraps modulo FIFO_DEPTH. The count has width log2(FIFO_DEPTH)+1.
- Reset mid-operation: FIFO contents, pending bits and cnt are discarded immediately. No write occurs after the reset edge.

Test Plan:
- Reset, then md push {rd=5, 0xDEADBEEF} with no pipe activity -> md_ready=1; next cycle RegWr=1, rd=5, busW=0xDEADBEEF; FIFO empty after.
- iss_valid with iss_rd=7, then dec_rs=7 -> stall=1 until the rd=7 result is written; stall=0 the cycle after the pop edge.
- Pipe writes every cycle while one md entry is queued -> pipe wins for 4 cycles, force=1 and stall=1 on the 5th, FIFO head written, cnt=0, force=0 next cycle.
- Push 2 md results with pipe busy -> md_ready=0 while full; md_valid held gets accepted only the cycle after a pop.
- Pipe write to rd=0 plus queued md entry rd=3 -> RegWr=1, rd=3 (FIFO takes the port); an md entry with rd=0 pops with RegWr=0.
- Assert rst_n=0 with a full FIFO and pending bits set -> RegWr=0 and md_ready=0 immediately; after release, FIFO empty, stall=0, no stale writes.
